// File: rtl/serial_pkg.sv
// Shared definitions for the stepper-driver serial link (receiver and transmitter).
//   ser_state_e  : frame state encoding (IDLE=0, SHIFT=1)
//   count_width  : bit-counter width for a given word size, never less than 1
package serial_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   function automatic int count_width(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/sipo_if.sv
// Parallel word handshake between the serial receiver and its consumer.
//   data_out       : received word, MSB = first bit on the wire
//   data_valid_out : data_out holds an unconsumed word
//   data_ready_in  : consumer accepts data_out this cycle
// master = receiver side, slave = consumer side.
interface sipo_if #(
   parameter int SIZE = 8
);
   logic [SIZE-1:0] data_out;
   logic            data_valid_out;
   logic            data_ready_in;

   modport master (
      output data_out,
      output data_valid_out,
      input  data_ready_in
   );

   modport slave (
      input  data_out,
      input  data_valid_out,
      output data_ready_in
   );
endinterface

// File: rtl/sipo_hold_reg.sv
// Output holding register for the serial receiver: captures each completed
// word, presents it through the valid/ready handshake and flags overruns.
//   clk_in, reset_in : clock, async active-high reset
//   word_done        : a word completes on this edge
//   word             : the completed word
//   rx               : handshake towards the consumer (master side)
//   overrun_out      : 1-cycle pulse, an unconsumed word was overwritten
//   overrun_cnt_out  : saturating overrun count; only built when
//                      SIPO_OVERRUN_CNT_EN is defined, otherwise tied to 0
module sipo_hold_reg #(
   parameter int SIZE = 8
) (
   input  logic            clk_in,
   input  logic            reset_in,
   input  logic            word_done,
   input  logic [SIZE-1:0] word,
   sipo_if.master          rx,
   output logic            overrun_out,
   output logic [7:0]      overrun_cnt_out
);

   logic overrun_nxt;

   // A completion that lands on a transfer edge is not an overrun: the old
   // word leaves as the new one arrives.
   assign overrun_nxt = word_done & rx.data_valid_out & ~rx.data_ready_in;

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         rx.data_out       <= '0;
         rx.data_valid_out <= 1'b0;
         overrun_out       <= 1'b0;
      end else begin
         overrun_out <= overrun_nxt;
         if (word_done) begin
            rx.data_out       <= word;
            rx.data_valid_out <= 1'b1;
         end else if (rx.data_valid_out && rx.data_ready_in) begin
            rx.data_valid_out <= 1'b0;
         end
      end
   end

`ifdef SIPO_OVERRUN_CNT_EN
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         overrun_cnt_out <= 8'h00;
      end else if (overrun_nxt && (overrun_cnt_out != 8'hFF)) begin
         overrun_cnt_out <= overrun_cnt_out + 8'h01;
      end
   end
`else
   assign overrun_cnt_out = 8'h00;
`endif

endmodule

// File: rtl/sipo.sv
// Serial-in/parallel-out receiver: deserialises a continuous MSB-first bit
// stream into SIZE-bit words, aligned to frames by sync_in.
//   clk_in, reset_in : clock, async active-high reset
//   data_in          : serial bit, sampled every edge
//   sync_in          : bit sampled this edge is the first (MSB) of a word
//   rx               : data_out / data_valid_out / data_ready_in handshake
//   overrun_out      : 1-cycle pulse, unconsumed word overwritten
//   frame_err_out    : 1-cycle pulse, sync_in arrived mid-word
//   overrun_cnt_out  : saturating overrun count (SIPO_OVERRUN_CNT_EN), else 0
//
// state | meaning
// IDLE  | unaligned, ignoring data_in until sync_in
// SHIFT | aligned, count = bits of the current word already received
module sipo
   import serial_pkg::*;
#(
   parameter int SIZE = 8
) (
   input  logic       clk_in,
   input  logic       reset_in,
   input  logic       data_in,
   input  logic       sync_in,
   sipo_if.master     rx,
   output logic       overrun_out,
   output logic       frame_err_out,
   output logic [7:0] overrun_cnt_out
);

   localparam int CW = count_width(SIZE);
   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

   ser_state_e       state, state_nxt;
   logic [CW-1:0]    count, count_nxt;
   // Only SIZE-1 bits need storing; the last bit goes straight into the word.
   logic [SIZE-2:0]  shift, shift_nxt;
   logic [SIZE-1:0]  word;
   logic             word_done;
   logic             frame_err_nxt;

   assign word = {shift, data_in};

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state         <= IDLE;
         count         <= '0;
         shift         <= '0;
         frame_err_out <= 1'b0;
      end else begin
         state         <= state_nxt;
         count         <= count_nxt;
         shift         <= shift_nxt;
         frame_err_out <= frame_err_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      shift_nxt     = shift;
      word_done     = 1'b0;
      frame_err_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (sync_in) begin
               shift_nxt = (SIZE-1)'(data_in);
               count_nxt = CW'(1);
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (sync_in && (count != '0)) begin
               // Misaligned sync: drop the partial word and realign here.
               shift_nxt     = (SIZE-1)'(data_in);
               count_nxt     = CW'(1);
               frame_err_nxt = 1'b1;
            end else if (count == LAST) begin
               word_done = 1'b1;
               shift_nxt = (SIZE-1)'(word);
               count_nxt = '0;
            end else begin
               shift_nxt = (SIZE-1)'(word);
               count_nxt = count + CW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   sipo_hold_reg #(
      .SIZE (SIZE)
   ) u_hold (
      .clk_in          (clk_in),
      .reset_in        (reset_in),
      .word_done       (word_done),
      .word            (word),
      .rx              (rx),
      .overrun_out     (overrun_out),
      .overrun_cnt_out (overrun_cnt_out)
   );

endmodule

// File: tb/tb_sipo.sv
// Directed bench for the serial receiver: SIZE=8 and SIZE=2 instances,
// hand-computed vectors plus a serialiser model loopback.
module tb_sipo;

   logic clk_in   = 1'b0;
   logic reset_in = 1'b0;
   logic d8 = 1'b0, s8 = 1'b0;
   logic d2 = 1'b0, s2 = 1'b0;
   logic ov8, fe8, ov2, fe2;
   logic [7:0] cnt8, cnt2;

   sipo_if #(.SIZE(8)) rx8 ();
   sipo_if #(.SIZE(2)) rx2 ();

   sipo #(.SIZE(8)) u_dut8 (
      .clk_in          (clk_in),
      .reset_in        (reset_in),
      .data_in         (d8),
      .sync_in         (s8),
      .rx              (rx8.master),
      .overrun_out     (ov8),
      .frame_err_out   (fe8),
      .overrun_cnt_out (cnt8)
   );

   sipo #(.SIZE(2)) u_dut2 (
      .clk_in          (clk_in),
      .reset_in        (reset_in),
      .data_in         (d2),
      .sync_in         (s2),
      .rx              (rx2.master),
      .overrun_out     (ov2),
      .frame_err_out   (fe2),
      .overrun_cnt_out (cnt2)
   );

   always #5 clk_in = ~clk_in;

   int n_chk  = 0;
   int n_pass = 0;
   int ov_cnt = 0, fe_cnt = 0, ov2_cnt = 0;
   logic [7:0] got8[$];
   logic [1:0] got2[$];
   logic [7:0] exp8[$];
   logic [1:0] exp2[$];

   always @(posedge clk_in) begin
      if (rx8.data_valid_out && rx8.data_ready_in) got8.push_back(rx8.data_out);
      if (rx2.data_valid_out && rx2.data_ready_in) got2.push_back(rx2.data_out);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic step8(input logic d, input logic s);
      d8 = d;
      s8 = s;
      @(posedge clk_in);
      #1;
      if (ov8) ov_cnt++;
      if (fe8) fe_cnt++;
   endtask

   task automatic step2(input logic d, input logic s);
      d2 = d;
      s2 = s;
      @(posedge clk_in);
      #1;
      if (ov2) ov2_cnt++;
   endtask

   // Sends the top nbits of w, MSB first, sync on the first bit if requested.
   task automatic send8(input logic [7:0] w, input int nbits, input logic sync_first);
      for (int i = 0; i < nbits; i++) step8(w[7-i], sync_first && (i == 0));
   endtask

   task automatic do_reset();
      d8 = 0; s8 = 0; d2 = 0; s2 = 0;
      reset_in = 1'b1;
      repeat (2) @(posedge clk_in);
      #1;
      reset_in = 1'b0;
      ov_cnt = 0; fe_cnt = 0; ov2_cnt = 0;
   endtask

   initial begin
      logic [7:0] w8;
      logic [1:0] w2;
      int errs;

      rx8.data_ready_in = 1'b0;
      rx2.data_ready_in = 1'b0;
      do_reset();
      chk("rst_valid", rx8.data_valid_out, 0);
      chk("rst_data", rx8.data_out, 0);
      chk("rst_ov", ov8, 0);
      chk("rst_fe", fe8, 0);
      chk("rst_cnt", cnt8, 0);

      // 1: single word A5, valid on the 8th edge
      send8(8'hA5, 7, 1'b1);
      chk("t1_valid_early", rx8.data_valid_out, 0);
      step8(1'b1, 1'b0);
      chk("t1_valid", rx8.data_valid_out, 1);
      chk("t1_data", rx8.data_out, 8'hA5);
      chk("t1_pulses", ov_cnt + fe_cnt, 0);
      rx8.data_ready_in = 1'b1;
      step8(1'b0, 1'b0);
      chk("t1_consumed", rx8.data_valid_out, 0);

      // 2: back-to-back 3C, C3 with ready high
      do_reset();
      got8.delete();
      rx8.data_ready_in = 1'b1;
      send8(8'h3C, 8, 1'b1);
      chk("t2_w1_data", rx8.data_out, 8'h3C);
      send8(8'hC3, 8, 1'b0);
      chk("t2_w2_data", rx8.data_out, 8'hC3);
      chk("t2_w2_valid", rx8.data_valid_out, 1);
      step8(1'b0, 1'b0);
      chk("t2_xfers", got8.size(), 2);
      if (got8.size() == 2) begin
         chk("t2_xfer0", got8[0], 8'h3C);
         chk("t2_xfer1", got8[1], 8'hC3);
      end
      chk("t2_no_ov", ov_cnt, 0);

      // 3: ready low, second word overruns the first
      do_reset();
      rx8.data_ready_in = 1'b0;
      send8(8'h11, 8, 1'b1);
      chk("t3_w1_ov", ov_cnt, 0);
      send8(8'h22, 8, 1'b0);
      chk("t3_ov_pulse", ov8, 1);
      chk("t3_data", rx8.data_out, 8'h22);
      chk("t3_valid", rx8.data_valid_out, 1);
`ifdef SIPO_OVERRUN_CNT_EN
      chk("t3_cnt", cnt8, 1);
`else
      chk("t3_cnt", cnt8, 0);
`endif
      step8(1'b0, 1'b0);
      chk("t3_ov_width", ov_cnt, 1);
      chk("t3_hold", rx8.data_out, 8'h22);

      // 4: sync at count 3 of FF, then 0F
      do_reset();
      send8(8'hFF, 3, 1'b1);
      chk("t4_no_fe_yet", fe_cnt, 0);
      step8(1'b0, 1'b1);
      chk("t4_fe_pulse", fe8, 1);
      chk("t4_no_word", rx8.data_valid_out, 0);
      send8(8'h0F << 1, 7, 1'b0);
      chk("t4_fe_width", fe_cnt, 1);
      chk("t4_data", rx8.data_out, 8'h0F);
      chk("t4_valid", rx8.data_valid_out, 1);

      // 5: async reset at count 5, then unsynced stream ignored
      do_reset();
      send8(8'h5A, 8, 1'b1);
      send8(8'hFF, 5, 1'b0);
      chk("t5_pre_valid", rx8.data_valid_out, 1);
      #2;
      reset_in = 1'b1;
      #1;
      chk("t5_rst_valid", rx8.data_valid_out, 0);
      chk("t5_rst_data", rx8.data_out, 0);
      @(posedge clk_in);
      #1;
      reset_in = 1'b0;
      send8(8'hFF, 8, 1'b0);
      send8(8'h81, 8, 1'b0);
      chk("t5_ignored", rx8.data_valid_out, 0);
      send8(8'h96, 8, 1'b1);
      chk("t5_data", rx8.data_out, 8'h96);
      chk("t5_valid", rx8.data_valid_out, 1);

      // SIZE=2 directed
      do_reset();
      step2(1'b1, 1'b1);
      chk("s2_early", rx2.data_valid_out, 0);
      step2(1'b0, 1'b0);
      chk("s2_valid", rx2.data_valid_out, 1);
      chk("s2_data", rx2.data_out, 2'b10);
      step2(1'b1, 1'b1);
      step2(1'b1, 1'b0);
      chk("s2_data2", rx2.data_out, 2'b11);
      chk("s2_fe", fe2, 0);

      // 6: loopback with serialiser model, random words
      do_reset();
      got8.delete(); exp8.delete();
      rx8.data_ready_in = 1'b1;
      for (int w = 0; w < 1000; w++) begin
         w8 = 8'($urandom_range(0, 255));
         exp8.push_back(w8);
         for (int i = 7; i >= 0; i--)
            step8(w8[i], (i == 7) && ((w == 0) || ($urandom_range(0, 3) == 0)));
      end
      step8(1'b0, 1'b0);
      chk("lb8_count", got8.size(), 1000);
      errs = 0;
      for (int k = 0; k < 1000; k++)
         if (k >= got8.size() || got8[k] !== exp8[k]) errs++;
      chk("lb8_errs", errs, 0);
      chk("lb8_ov_fe", ov_cnt + fe_cnt, 0);

      got2.delete(); exp2.delete();
      rx2.data_ready_in = 1'b1;
      for (int w = 0; w < 1000; w++) begin
         w2 = 2'($urandom_range(0, 3));
         exp2.push_back(w2);
         step2(w2[1], (w == 0) || ($urandom_range(0, 3) == 0));
         step2(w2[0], 1'b0);
      end
      step2(1'b0, 1'b0);
      chk("lb2_count", got2.size(), 1000);
      errs = 0;
      for (int k = 0; k < 1000; k++)
         if (k >= got2.size() || got2[k] !== exp2[k]) errs++;
      chk("lb2_errs", errs, 0);
      chk("lb2_ov", ov2_cnt, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
